gpio_bank: RTL and testbench
============================

# gpio_bank

Parametrised memory-mapped GPIO controller for the J1 Forth FPGA, replacing the fixed 8-pin output/output-enable/input scheme of the CSR block with a self-contained bank. It adds input synchronisation, per-pin debounce, atomic set/clear/toggle, edge-event capture and a level interrupt. It sits on the J1 I/O bus (`io_wr`/`io_rd`, address, `dout`/`io_din`). The top level owns tristate pads, driven from `gpio_out`/`gpio_oe`.

## Interface
- `WIDTH`, 8: number of pins, 1..16.
- `DATA_WIDTH`, 16: I/O bus width, at least `WIDTH`.
- `SYNC_STAGES`, 2: input synchroniser depth, at least 2.
- `DB_BITS`, 8: debounce counter and threshold width.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous and active-low. Asserting it clears all state immediately.
- `io_addr` in 4: word register offset.
- `io_wdata` in `DATA_WIDTH`: write data.
- `io_wr` in 1: single-cycle write strobe.
- `io_rd` in 1: single-cycle read strobe.
- `io_rdata` out `DATA_WIDTH`: registered read data.
- `gpio_in` in `WIDTH`: raw, asynchronous pad inputs.
- `gpio_out` out `WIDTH`: output data.
- `gpio_oe` out `WIDTH`: output enable; 1 means drive.
- `irq` out 1: registered level interrupt.

## Operation
Register map. Bits at or above `WIDTH` read 0 and ignore writes.
- 0 OUT, RW.
- 1 OE, RW.
- 2 IN, RO: debounced input state.
- 3 SET, WO: OUT |= wdata.
- 4 CLR, WO: OUT &= ~wdata.
- 5 TGL, WO: OUT ^= wdata.
- 6 RISE_EN, RW.
- 7 FALL_EN, RW.
- 8 EVENT, R/W1C.
- 9 IRQ_EN, RW.
- 10 DB_THRESH, RW, `DB_BITS` wide.
- 11–15: unmapped. Reads return 0; writes are ignored.
- WO registers read 0.

Input path, per pin:
- `SYNC_STAGES` flops feed a synced value `s`.
- A stable register `q` is the value IN reports.
- A `DB_BITS` mismatch counter `c` runs per pin:
  - If `s == q`: `c` ← 0.
  - Otherwise `c` increments each cycle. On the edge where `c + 1 >= max(DB_THRESH, 1)`, `q` ← `s` and `c` ← 0.
  - A threshold of 0 therefore behaves as 1: `q` follows `s` with one cycle of delay.
- A glitch shorter than the threshold never reaches `q`.
- The counter saturates, so it never wraps.

Edge detection and interrupt:
- `q_d` is `q` delayed by one cycle.
- A rising event is `q & ~q_d & RISE_EN`; a falling event is `~q & q_d & FALL_EN`.
- Either event sets the corresponding EVENT bit on the next edge.
- If set and W1C hit the same bit in the same cycle, set wins.
- Disabling RISE_EN or FALL_EN does not clear bits already in EVENT.
- `irq` ← |(EVENT & IRQ_EN), registered.

Bus:
- A write takes effect on the edge where `io_wr` = 1.
- A read captures into `io_rdata` on the edge where `io_rd` = 1. `io_rdata` holds until the next read.
- If `io_wr` and `io_rd` are both high in one cycle, both execute and the read returns the pre-write value. This applies to an EVENT read with W1C too: the read returns pre-clear data.

Reset values:
- `gpio_out`, `gpio_oe`, `irq` and `io_rdata` are 0.
- All registers, synchroniser flops, `q`, `q_d` and counters are 0.
- A pin held high through reset raises `q` after the synchroniser delay. This sets no event, because RISE_EN resets to 0.
- Asserting reset mid-debounce discards the count.

## Timing
- Pad change first sampled at edge E:
  - `s` at E+`SYNC_STAGES`−1.
  - `q` at E+`SYNC_STAGES`−1+max(T,1).
  - EVENT one edge after `q`.
  - `irq` one edge after EVENT.
  - With S=2 and T=0: `q` at E+2, EVENT at E+3, `irq` at E+4.
- Register write to `gpio_out`/`gpio_oe`: visible one edge after the write strobe.
- Read latency: one cycle. Data is valid in the cycle after the `io_rd` cycle.
- An IRQ_EN write or EVENT clear affects `irq` one edge after the register changes: two edges after the strobe.
- Changing DB_THRESH mid-count takes effect immediately against the current `c`.

## Test plan
- Reset and map:
  - Stimulus: drop `rst_n` mid-operation, release it, then read every offset.
  - Required: all reads 0 and `irq` 0. Write OUT=0x00A5 and read back 0x00A5. Write 0xFFFF to OE with WIDTH=8 and read back 0x00FF.
- Atomic ops:
  - Stimulus: OUT=0x0F, SET 0x30, CLR 0x03, TGL 0x81.
  - Required: `gpio_out` is 0x3F, 0x3C, 0xBD, each one edge after its strobe.
- Debounce:
  - Stimulus: DB_THRESH=4; pulse pin 0 high for 3 cycles, then hold it high for 10.
  - Required: the pulse never changes IN. Sustained high: IN bit 0 = 1 at E+1+4, with E the edge that first samples the sustained high. With S=2, that is edge E+5.
- Edge events and interrupt:
  - Stimulus: RISE_EN=0x01, FALL_EN=0x02, IRQ_EN=0x03, T=0; raise pin 0, drop pin 1 (previously high).
  - Required: EVENT=0x03, and `irq` goes high 4 edges after sampling. W1C 0x01 leaves EVENT=0x02 with `irq` still 1. W1C 0x02 drops `irq` two edges after the strobe.
- Set/clear collision:
  - Stimulus: a rising event on pin 2 in the same cycle as a W1C of 0x04.
  - Required: EVENT bit 2 remains 1. A simultaneous read returns the pre-clear value.
- Wide config:
  - Stimulus: WIDTH=16, SYNC_STAGES=3; toggle pin 15.
  - Required: IN bit 15 follows with 3-cycle latency at T=0.

Source files
------------

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with input synchronisation, per-pin
// debounce, atomic set/clear/toggle, edge-event capture and level interrupt.
//
// Ports:
//   clk_i, rst_n_i          sole clock, async active-low reset
//   io_addr_i               word register offset
//   io_wdata_i, io_wr_i     write data / single-cycle write strobe
//   io_rd_i, io_rdata_o     single-cycle read strobe / registered read data
//   gpio_in_i               raw asynchronous pad inputs
//   gpio_out_o, gpio_oe_o   pad output data / output enable (1 = drive)
//   irq_o                   registered level interrupt
//
// Register map: 0 OUT, 1 OE, 2 IN, 3 SET, 4 CLR, 5 TGL, 6 RISE_EN,
// 7 FALL_EN, 8 EVENT (W1C), 9 IRQ_EN, 10 DB_THRESH, 11-15 unmapped.
module gpio_bank #(
  parameter int WIDTH       = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_BITS     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [3:0]            io_addr_i,
  input  logic [DATA_WIDTH-1:0] io_wdata_i,
  input  logic                  io_wr_i,
  input  logic                  io_rd_i,
  output logic [DATA_WIDTH-1:0] io_rdata_o,
  input  logic [WIDTH-1:0]      gpio_in_i,
  output logic [WIDTH-1:0]      gpio_out_o,
  output logic [WIDTH-1:0]      gpio_oe_o,
  output logic                  irq_o
);

  localparam int TW = (DB_BITS < DATA_WIDTH) ? DB_BITS : DATA_WIDTH;

  logic [WIDTH-1:0]      out_q, out_d, oe_q, oe_d;
  logic [WIDTH-1:0]      rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [WIDTH-1:0]      event_q, event_d, irq_en_q, irq_en_d;
  logic [DB_BITS-1:0]    thresh_q, thresh_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  irq_q, irq_d;

  logic [WIDTH-1:0]      sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]      stable_q, stable_d, stable_dly_q;
  logic [DB_BITS-1:0]    cnt_q [WIDTH];
  logic [DB_BITS-1:0]    cnt_d [WIDTH];

  logic [WIDTH-1:0]      synced, wsel, w1c, rise, fall;
  logic [DB_BITS-1:0]    thr_eff;
  logic [DB_BITS:0]      cnt_nx;
  logic [DATA_WIDTH-1:0] rd_val;

  assign synced = sync_q[SYNC_STAGES-1];
  assign wsel   = io_wdata_i[WIDTH-1:0];

  // A threshold of zero behaves as one so q always trails s by at least a cycle.
  assign thr_eff = (thresh_q == '0) ? DB_BITS'(1) : thresh_q;

  assign rise = stable_q & ~stable_dly_q & rise_en_q;
  assign fall = ~stable_q & stable_dly_q & fall_en_q;

  always_comb begin
    stable_d = stable_q;
    cnt_nx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      cnt_nx   = {1'b0, cnt_q[i]} + {{DB_BITS{1'b0}}, 1'b1};
      if (synced[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_nx >= {1'b0, thr_eff}) begin
        stable_d[i] = synced[i];
        cnt_d[i]    = '0;
      end else if (!(&cnt_q[i])) begin
        cnt_d[i] = cnt_nx[DB_BITS-1:0];
      end
    end
  end

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_en_d  = irq_en_q;
    thresh_d  = thresh_q;
    w1c       = '0;
    if (io_wr_i) begin
      case (io_addr_i)
        4'd0:  out_d     = wsel;
        4'd1:  oe_d      = wsel;
        4'd3:  out_d     = out_q | wsel;
        4'd4:  out_d     = out_q & ~wsel;
        4'd5:  out_d     = out_q ^ wsel;
        4'd6:  rise_en_d = wsel;
        4'd7:  fall_en_d = wsel;
        4'd8:  w1c       = wsel;
        4'd9:  irq_en_d  = wsel;
        4'd10: begin
          thresh_d         = '0;
          thresh_d[TW-1:0] = io_wdata_i[TW-1:0];
        end
        default: ;
      endcase
    end
    // New events are OR-ed in after the clear, so a same-cycle set wins.
    event_d = (event_q & ~w1c) | rise | fall;
    irq_d   = |(event_q & irq_en_q);
  end

  // Reads sample current register state, so a concurrent write is not seen.
  always_comb begin
    rd_val  = '0;
    rdata_d = rdata_q;
    case (io_addr_i)
      4'd0:  rd_val[WIDTH-1:0] = out_q;
      4'd1:  rd_val[WIDTH-1:0] = oe_q;
      4'd2:  rd_val[WIDTH-1:0] = stable_q;
      4'd6:  rd_val[WIDTH-1:0] = rise_en_q;
      4'd7:  rd_val[WIDTH-1:0] = fall_en_q;
      4'd8:  rd_val[WIDTH-1:0] = event_q;
      4'd9:  rd_val[WIDTH-1:0] = irq_en_q;
      4'd10: rd_val[TW-1:0]    = thresh_q[TW-1:0];
      default: ;
    endcase
    if (io_rd_i) rdata_d = rd_val;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q        <= '0;
      oe_q         <= '0;
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      event_q      <= '0;
      irq_en_q     <= '0;
      thresh_q     <= '0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      out_q        <= out_d;
      oe_q         <= oe_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      event_q      <= event_d;
      irq_en_q     <= irq_en_d;
      thresh_q     <= thresh_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      sync_q[0]    <= gpio_in_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign gpio_out_o = out_q;
  assign gpio_oe_o  = oe_q;
  assign io_rdata_o = rdata_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Testbench for gpio_bank: a narrow instance (WIDTH=8, SYNC_STAGES=2) and a
// wide instance (WIDTH=16, SYNC_STAGES=3) share the bus. Read expectations go
// into a queue; a monitor pops and compares on the cycle after each read strobe.
module tb_gpio_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  io_addr = '0;
  logic [15:0] io_wdata = '0;
  logic        io_wr = 1'b0;
  logic        io_rd = 1'b0;
  logic [15:0] rdata8, rdata16;
  logic [7:0]  gin8 = '0;
  logic [15:0] gin16 = '0;
  logic [7:0]  out8, oe8;
  logic [15:0] out16, oe16;
  logic        irq8, irq16;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic        rd_fire = 1'b0;
  logic        mon_sel = 1'b0;

  always #5 clk = ~clk;

  gpio_bank #(.WIDTH(8), .DATA_WIDTH(16), .SYNC_STAGES(2), .DB_BITS(8)) dut_n (
    .clk_i(clk), .rst_n_i(rst_n), .io_addr_i(io_addr), .io_wdata_i(io_wdata),
    .io_wr_i(io_wr), .io_rd_i(io_rd), .io_rdata_o(rdata8), .gpio_in_i(gin8),
    .gpio_out_o(out8), .gpio_oe_o(oe8), .irq_o(irq8)
  );

  gpio_bank #(.WIDTH(16), .DATA_WIDTH(16), .SYNC_STAGES(3), .DB_BITS(8)) dut_w (
    .clk_i(clk), .rst_n_i(rst_n), .io_addr_i(io_addr), .io_wdata_i(io_wdata),
    .io_wr_i(io_wr), .io_rd_i(io_rd), .io_rdata_o(rdata16), .gpio_in_i(gin16),
    .gpio_out_o(out16), .gpio_oe_o(oe16), .irq_o(irq16)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: the read strobe captured at a posedge is checked on the next negedge.
  always @(posedge clk) rd_fire <= io_rd;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got read data %h expected no read", mon_sel ? rdata16 : rdata8);
      end else begin
        check(mon_sel ? "rd_wide" : "rd_narrow", mon_sel ? rdata16 : rdata8, exp_q.pop_front());
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e);
    @(negedge clk);
    io_addr = a; io_rd = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    io_rd = 1'b0;
  endtask

  // Back-to-back reads starting at the current negedge; read j returns v1 once j >= flip.
  task automatic burst(input logic [3:0] a, input int n, input int flip,
                       input logic [15:0] v0, input logic [15:0] v1);
    io_addr = a; io_rd = 1'b1;
    for (int j = 0; j < n; j++) begin
      exp_q.push_back((j >= flip) ? v1 : v0);
      @(negedge clk);
    end
    io_rd = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset and map: dirty some state, then reset in the middle of a write.
    wr(4'd0, 16'h00FF);
    wr(4'd9, 16'h00FF);
    wr(4'd10, 16'h0007);
    check("out_pre_reset", {8'h00, out8}, 16'h00FF);
    @(negedge clk);
    io_addr = 4'd1; io_wdata = 16'h00FF; io_wr = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("async_reset_out", {8'h00, out8}, 16'h0000);
    @(negedge clk);
    io_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) rd(a[3:0], 16'h0000);
    check("irq_after_reset", {15'h0, irq8}, 16'h0000);
    check("oe_after_reset", {8'h00, oe8}, 16'h0000);
    wr(4'd0, 16'h00A5);
    rd(4'd0, 16'h00A5);
    wr(4'd1, 16'hFFFF);
    rd(4'd1, 16'h00FF);
    check("oe_pin", {8'h00, oe8}, 16'h00FF);
    wr(4'd11, 16'hFFFF);
    rd(4'd11, 16'h0000);
    rd(4'd3, 16'h0000);

    // Atomic set / clear / toggle.
    wr(4'd0, 16'h000F);
    wr(4'd3, 16'h0030);
    check("set", {8'h00, out8}, 16'h003F);
    wr(4'd4, 16'h0003);
    check("clr", {8'h00, out8}, 16'h003C);
    wr(4'd5, 16'h0081);
    check("tgl", {8'h00, out8}, 16'h00BD);

    // Debounce at threshold 4: a 3-cycle pulse is filtered.
    wr(4'd10, 16'h0004);
    rd(4'd10, 16'h0004);
    @(negedge clk);
    gin8[0] = 1'b1;
    burst(4'd2, 3, 99, 16'h0000, 16'h0000);
    gin8[0] = 1'b0;
    burst(4'd2, 8, 99, 16'h0000, 16'h0000);
    // Sustained high: q rises at E+5, so the read strobed at E+6 is the first to see it.
    gin8[0] = 1'b1;
    burst(4'd2, 9, 6, 16'h0000, 16'h0001);
    repeat (4) @(negedge clk);

    // Edge events and interrupt at threshold 0.
    wr(4'd10, 16'h0000);
    gin8[0] = 1'b0; gin8[1] = 1'b1;
    repeat (6) @(negedge clk);
    rd(4'd2, 16'h0002);
    wr(4'd6, 16'h0001);
    wr(4'd7, 16'h0002);
    wr(4'd9, 16'h0003);
    gin8[0] = 1'b1; gin8[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("irq_before_E4", {15'h0, irq8}, 16'h0000);
    @(negedge clk);
    check("irq_at_E4", {15'h0, irq8}, 16'h0001);
    rd(4'd8, 16'h0003);
    wr(4'd8, 16'h0001);
    rd(4'd8, 16'h0002);
    check("irq_after_w1c1", {15'h0, irq8}, 16'h0001);
    wr(4'd8, 16'h0002);
    check("irq_strobe_plus1", {15'h0, irq8}, 16'h0001);
    @(negedge clk);
    check("irq_strobe_plus2", {15'h0, irq8}, 16'h0000);
    rd(4'd8, 16'h0000);
    wr(4'd6, 16'h0000);
    rd(4'd8, 16'h0000);

    // Set/clear collision on pin 2.
    wr(4'd6, 16'h0005);
    gin8[2] = 1'b1;
    repeat (5) @(negedge clk);
    rd(4'd8, 16'h0004);
    gin8[2] = 1'b0;
    repeat (4) @(negedge clk);
    rd(4'd8, 16'h0004);
    gin8[2] = 1'b1;
    repeat (3) @(negedge clk);
    io_addr = 4'd8; io_wdata = 16'h0004; io_wr = 1'b1; io_rd = 1'b1;
    exp_q.push_back(16'h0004);
    @(negedge clk);
    io_wr = 1'b0; io_rd = 1'b0;
    rd(4'd8, 16'h0004);
    check("irq_masked", {15'h0, irq8}, 16'h0000);

    // Wide instance: pin 15, three synchroniser stages, threshold 0.
    repeat (2) @(negedge clk);
    mon_sel = 1'b1;
    rd(4'd2, 16'h0000);
    gin16[15] = 1'b1;
    burst(4'd2, 6, 4, 16'h0000, 16'h8000);
    gin16[15] = 1'b0;
    burst(4'd2, 6, 4, 16'h8000, 16'h0000);
    wr(4'd1, 16'hFFFF);
    rd(4'd1, 16'hFFFF);

    repeat (3) @(negedge clk);
    check("sb_drain", 16'(exp_q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
